// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter of NUM_CH sram-like channels onto one memory port with in-order response routing
module mem_req_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_wr,
  input  logic [2*NUM_CH-1:0]        ch_size,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_wstrb,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_addr_ok,
  output logic [NUM_CH-1:0]          ch_data_ok,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [1:0]                 mem_size,
  output logic [DATA_W/8-1:0]        mem_wstrb,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       resp_err
);
  localparam int SW = DATA_W / 8;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  typedef enum logic {ARB, LOCK} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_lock_ch;
  logic [IW-1:0]     r_rr;
  logic [IW-1:0]     r_tag [MAX_OUTST];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_cnt;
  logic              r_resp_err;

  logic [IW-1:0]     w_arb_gnt;
  logic [IW-1:0]     w_gnt;
  logic              w_full;
  logic              w_accept;
  logic              w_pop;
  logic [1:0]        w_size_a  [NUM_CH];
  logic [SW-1:0]     w_strb_a  [NUM_CH];
  logic [ADDR_W-1:0] w_addr_a  [NUM_CH];
  logic [DATA_W-1:0] w_wdata_a [NUM_CH];

  // Round robin: lowest requesting channel at or after r_rr wins, else lowest below it
  always_comb begin
    w_arb_gnt = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (ch_req[c] && c < int'(r_rr)) w_arb_gnt = IW'(c);
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (ch_req[c] && c >= int'(r_rr)) w_arb_gnt = IW'(c);
  end

  // Unpack the flat per-channel request buses into indexable arrays
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_size_a[c]  = ch_size[2*c +: 2];
      w_strb_a[c]  = ch_wstrb[c*SW +: SW];
      w_addr_a[c]  = ch_addr[c*ADDR_W +: ADDR_W];
      w_wdata_a[c] = ch_wdata[c*DATA_W +: DATA_W];
    end
  end

  assign w_gnt    = (r_state == LOCK) ? r_lock_ch : w_arb_gnt;
  assign w_full   = r_cnt == CW'(MAX_OUTST);
  // Outputs are gated by resetn so they drop immediately when reset asserts
  assign mem_req  = resetn & ((r_state == LOCK) | (|ch_req & ~w_full));
  assign w_accept = mem_req & mem_addr_ok;
  assign w_pop    = resetn & mem_data_ok & (r_cnt != '0);

  assign mem_wr    = ch_wr[w_gnt];
  assign mem_size  = w_size_a[w_gnt];
  assign mem_wstrb = w_strb_a[w_gnt];
  assign mem_addr  = w_addr_a[w_gnt];
  assign mem_wdata = w_wdata_a[w_gnt];
  assign ch_rdata  = mem_rdata;
  assign resp_err  = r_resp_err;

  // One-hot acknowledge of the granted channel and of the channel at the FIFO head
  always_comb begin
    ch_addr_ok = '0;
    ch_data_ok = '0;
    if (w_accept) ch_addr_ok[w_gnt] = 1'b1;
    if (w_pop) ch_data_ok[r_tag[r_rp]] = 1'b1;
  end

  // Arbitration FSM: a refused request freezes the grant until memory accepts it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ARB;
      r_lock_ch <= '0;
      r_rr      <= '0;
    end else begin
      if (w_accept) r_rr <= (w_gnt == IW'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
      case (r_state)
        ARB: if (mem_req && !mem_addr_ok) begin
          r_state   <= LOCK;
          r_lock_ch <= w_arb_gnt;
        end
        LOCK: if (mem_addr_ok) r_state <= ARB;
        default: r_state <= ARB;
      endcase
    end
  end

  // Tag FIFO of issuing channel ids, popped as in-order responses return
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < MAX_OUTST; i++) r_tag[i] <= '0;
    end else begin
      if (w_accept) begin
        r_tag[r_wp] <= w_gnt;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_accept) - CW'(w_pop);
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_resp_err <= 1'b0;
    else if (mem_data_ok && r_cnt == '0) r_resp_err <= 1'b1;
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: scoreboard bench with a queue-based reference model of arbitration and response routing
module tb_mem_req_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [N-1:0]      ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [2*N-1:0]    ch_size;
  logic [N*SW-1:0]   ch_wstrb;
  logic [N*AW-1:0]   ch_addr;
  logic [N*DW-1:0]   ch_wdata;
  logic [DW-1:0]     ch_rdata;
  logic              mem_req, mem_wr, mem_addr_ok, mem_data_ok, resp_err;
  logic [1:0]        mem_size;
  logic [SW-1:0]     mem_wstrb;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;

  bit            t_pend [N];
  logic          t_wr [N];
  logic [1:0]    t_size [N];
  logic [SW-1:0] t_strb [N];
  logic [AW-1:0] t_addr [N];
  logic [DW-1:0] t_wdata [N];

  int checks = 0, errors = 0;
  int rr = 0, lock = -1, outst = 0, last_g = -1;
  int mq[$];
  int sb_ch[$];
  logic [DW-1:0] sb_d[$];
  bit resp_now = 0;

  mem_req_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok),
    .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_wstrb = '0; ch_addr = '0; ch_wdata = '0;
    for (int c = 0; c < N; c++) begin
      ch_req[c] = t_pend[c];
      ch_wr[c] = t_wr[c];
      ch_size[2*c +: 2] = t_size[c];
      ch_wstrb[c*SW +: SW] = t_strb[c];
      ch_addr[c*AW +: AW] = t_addr[c];
      ch_wdata[c*DW +: DW] = t_wdata[c];
    end
  end

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask

  task automatic new_req(int c, logic wr, logic [AW-1:0] a);
    t_pend[c] = 1'b1;
    t_wr[c] = wr;
    t_size[c] = 2'($urandom_range(0, 2));
    t_strb[c] = SW'($urandom);
    t_addr[c] = a;
    t_wdata[c] = $urandom;
  endtask

  task automatic mem_respond(logic [DW-1:0] d);
    mem_data_ok = 1'b1;
    mem_rdata = d;
    if (mq.size() > 0) begin
      sb_ch.push_back(mq.pop_front());
      sb_d.push_back(d);
      resp_now = 1'b1;
    end
  endtask

  // One clock of the reference model: predict grant/request at negedge, commit after posedge
  task automatic cycle();
    int g;
    bit ereq, acc;
    @(negedge clk);
    g = -1;
    if (lock >= 0) g = lock;
    else for (int k = 0; k < N; k++) if (g < 0 && t_pend[(rr + k) % N]) g = (rr + k) % N;
    ereq = (lock >= 0) || (g >= 0 && outst < MO);
    chk("mem_req", 64'(mem_req), 64'(ereq));
    if (ereq) begin
      chk("mem_addr", mem_addr, t_addr[g]);
      chk("mem_wr", 64'(mem_wr), 64'(t_wr[g]));
      chk("mem_size", mem_size, t_size[g]);
      chk("mem_wstrb", mem_wstrb, t_strb[g]);
      chk("mem_wdata", mem_wdata, t_wdata[g]);
    end
    acc = ereq && mem_addr_ok;
    chk("ch_addr_ok", ch_addr_ok, acc ? (1 << g) : 0);
    @(posedge clk);
    #1;
    if (acc) begin
      mq.push_back(g);
      outst++;
      rr = (g + 1) % N;
      lock = -1;
      t_pend[g] = 1'b0;
      last_g = g;
    end else if (ereq) lock = g;
    if (resp_now) outst--;
    resp_now = 1'b0;
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((t_pend[0] || t_pend[1] || mq.size() > 0) && i < 200) begin
      mem_addr_ok = 1'b1;
      if (mq.size() > 0) mem_respond($urandom);
      cycle();
      i++;
    end
    chk("drain_done", 64'(int'(t_pend[0]) + int'(t_pend[1]) + mq.size()), 0);
  endtask

  task automatic run_rand(int n, int pr, int pa, int pd);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < N; c++)
        if (!t_pend[c] && $urandom_range(0, 99) < pr) new_req(c, 1'($urandom), $urandom);
      mem_addr_ok = $urandom_range(0, 99) < pa;
      if (mq.size() > 0 && $urandom_range(0, 99) < pd) mem_respond($urandom);
      cycle();
    end
  endtask

  // Response monitor: every DUT response must match the next scoreboard entry
  always @(negedge clk) begin
    int c;
    if (resetn) begin
      if (mem_data_ok && sb_ch.size() > 0) begin
        c = sb_ch.pop_front();
        chk("ch_data_ok", ch_data_ok, 1 << c);
        chk("ch_rdata", ch_rdata, sb_d.pop_front());
      end else chk("no_data_ok", ch_data_ok, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    for (int c = 0; c < N; c++) begin
      t_pend[c] = 0; t_wr[c] = 0; t_size[c] = 0; t_strb[c] = 0; t_addr[c] = 0; t_wdata[c] = 0;
    end
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    new_req(0, 1'b0, 32'h10);
    new_req(1, 1'b1, 32'h20);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    #1;
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_addr_ok", ch_addr_ok, 0);
    chk("rst_data_ok", ch_data_ok, 0);
    chk("rst_resp_err", 64'(resp_err), 0);
    t_pend[0] = 0; t_pend[1] = 0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    resetn = 1'b1;
    // single read on ch0, response two cycles after accept
    new_req(0, 1'b0, 32'h100);
    mem_addr_ok = 1'b1;
    cycle();
    chk("t1_grant", 64'(last_g), 0);
    cycle();
    mem_respond(32'h1234_5678);
    cycle();
    cycle();
    // both channels requesting continuously: grants alternate
    s = rr;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < N; c++) if (!t_pend[c]) new_req(c, 1'($urandom), 32'(c * 32'h1000 + i * 4));
      mem_addr_ok = 1'b1;
      if (mq.size() > 0) mem_respond($urandom);
      cycle();
      chk("t2_alt", 64'(last_g), 64'((s + i) % N));
    end
    drain();
    // ch1 refused for three cycles stays locked while ch0 joins
    new_req(1, 1'b1, 32'h2000);
    cycle();
    new_req(0, 1'b0, 32'h3000);
    cycle();
    cycle();
    mem_addr_ok = 1'b1;
    cycle();
    chk("t3_lock", 64'(last_g), 1);
    mem_addr_ok = 1'b1;
    cycle();
    chk("t3_next", 64'(last_g), 0);
    drain();
    // fill the tag FIFO, then free one slot
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < N; c++) if (!t_pend[c]) new_req(c, 1'($urandom), $urandom);
      mem_addr_ok = 1'b1;
      cycle();
    end
    chk("t4_full", 64'(mem_req), 0);
    mem_addr_ok = 1'b1;
    mem_respond($urandom);
    cycle();
    chk("t4_reenable", 64'(mem_req), 1);
    mem_addr_ok = 1'b1;
    mem_respond($urandom);
    cycle();
    chk("t4_push_pop", 64'(mem_req), 1);
    for (int c = 0; c < N; c++) if (!t_pend[c]) new_req(c, 1'($urandom), $urandom);
    mem_addr_ok = 1'b1;
    cycle();
    chk("t4_refull", 64'(mem_req), 0);
    drain();
    // response with nothing outstanding
    mem_data_ok = 1'b1;
    cycle();
    chk("t5_err", 64'(resp_err), 1);
    repeat (3) cycle();
    chk("t5_sticky", 64'(resp_err), 1);
    // asynchronous reset with three requests in flight
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < N; c++) if (!t_pend[c]) new_req(c, 1'($urandom), $urandom);
      mem_addr_ok = 1'b1;
      cycle();
    end
    for (int c = 0; c < N; c++) if (!t_pend[c]) new_req(c, 1'($urandom), $urandom);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_mem_req", 64'(mem_req), 0);
    chk("t6_addr_ok", ch_addr_ok, 0);
    chk("t6_data_ok", ch_data_ok, 0);
    chk("t6_resp_err", 64'(resp_err), 0);
    mq.delete(); sb_ch.delete(); sb_d.delete();
    outst = 0; rr = 0; lock = -1; resp_now = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mem_addr_ok = 1'b1;
    cycle();
    chk("t6_first", 64'(last_g), 0);
    // randomized traffic with different pressure mixes
    run_rand(300, 60, 60, 50);
    run_rand(150, 90, 90, 5);
    run_rand(300, 50, 40, 70);
    drain();
    chk("final_resp_err", 64'(resp_err), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
